// File: rtl/bira_pkg.sv
// Shared BIRA definitions: analyzer FSM states, default address/bank widths
// and the pivot-entry record used when describing a selected spare line.
package bira_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_BNK_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } npc_state_e;

  // One selected pivot line at default widths. A shared entry matches the
  // address in every bank.
  typedef struct packed {
    logic                  en;
    logic                  shared;
    logic [DEF_BNK_W-1:0]  bnk;
    logic [DEF_ADDR_W-1:0] addr;
  } pivot_entry_t;

endpackage

// File: rtl/nonpivot_cover_checker_if.sv
// Fault-stream and verdict handshake bundle for nonpivot_cover_checker.
// With NPC_FAIL_LOG_EN defined it also carries the first-uncovered-fault log.
interface nonpivot_cover_checker_if
  import bira_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BNK_W  = DEF_BNK_W,
  parameter int CNT_W  = 8
) ();

  logic              np_valid;
  logic              np_ready;
  logic [ADDR_W-1:0] np_row;
  logic [ADDR_W-1:0] np_col;
  logic [BNK_W-1:0]  np_bnk;
  logic              np_last;

  logic              res_valid;
  logic              res_ack;
  logic              res_pass;
  logic [CNT_W-1:0]  res_uncov_cnt;
  logic [CNT_W-1:0]  res_fault_cnt;

`ifdef NPC_FAIL_LOG_EN
  logic [ADDR_W-1:0] res_fail_row;
  logic [ADDR_W-1:0] res_fail_col;
  logic [BNK_W-1:0]  res_fail_bnk;
  logic              res_fail_seen;

  modport master (
    output np_valid, np_row, np_col, np_bnk, np_last, res_ack,
    input  np_ready, res_valid, res_pass, res_uncov_cnt, res_fault_cnt,
    input  res_fail_row, res_fail_col, res_fail_bnk, res_fail_seen
  );

  modport slave (
    input  np_valid, np_row, np_col, np_bnk, np_last, res_ack,
    output np_ready, res_valid, res_pass, res_uncov_cnt, res_fault_cnt,
    output res_fail_row, res_fail_col, res_fail_bnk, res_fail_seen
  );
`else
  modport master (
    output np_valid, np_row, np_col, np_bnk, np_last, res_ack,
    input  np_ready, res_valid, res_pass, res_uncov_cnt, res_fault_cnt
  );

  modport slave (
    input  np_valid, np_row, np_col, np_bnk, np_last, res_ack,
    output np_ready, res_valid, res_pass, res_uncov_cnt, res_fault_cnt
  );
`endif

endinterface

// File: rtl/nonpivot_cover_checker_line_match.sv
// npc_line_match: does one pivot slot cover a fault? Rows use shared_i to
// ignore the bank (cross-bank spare); columns tie shared_i low.
module npc_line_match #(
  parameter int ADDR_W = 10,
  parameter int BNK_W  = 2
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [BNK_W-1:0]  bnk_i,
  input  logic              en_i,
  input  logic              shared_i,
  input  logic [ADDR_W-1:0] flt_addr_i,
  input  logic [BNK_W-1:0]  flt_bnk_i,
  output logic              hit_o
);

  assign hit_o = en_i && (addr_i == flt_addr_i) && (shared_i || (bnk_i == flt_bnk_i));

endmodule

// File: rtl/nonpivot_cover_checker.sv
// nonpivot_cover_checker: latches the selected pivot rows/columns on start,
// checks each non-pivot fault beat for coverage through a one-stage compare
// pipeline and reports a pass/fail verdict with saturating fault counts.
// Optional feature macro: NPC_FAIL_LOG_EN (log the first uncovered fault).
module nonpivot_cover_checker
  import bira_pkg::*;
#(
  parameter int NUM_PR = 4,
  parameter int NUM_PC = 4,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BNK_W  = DEF_BNK_W,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_PR*ADDR_W-1:0] pr_addr,
  input  logic [NUM_PR*BNK_W-1:0]  pr_bnk,
  input  logic [NUM_PR-1:0]        pr_en,
  input  logic [NUM_PR-1:0]        pr_shared,
  input  logic [NUM_PC*ADDR_W-1:0] pc_addr,
  input  logic [NUM_PC*BNK_W-1:0]  pc_bnk,
  input  logic [NUM_PC-1:0]        pc_en,
  output logic                     busy,
  nonpivot_cover_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  npc_state_e state_q, state_d;

  logic [NUM_PR*ADDR_W-1:0] pr_addr_q;
  logic [NUM_PR*BNK_W-1:0]  pr_bnk_q;
  logic [NUM_PR-1:0]        pr_en_q;
  logic [NUM_PR-1:0]        pr_shared_q;
  logic [NUM_PC*ADDR_W-1:0] pc_addr_q;
  logic [NUM_PC*BNK_W-1:0]  pc_bnk_q;
  logic [NUM_PC-1:0]        pc_en_q;

  logic [NUM_PR-1:0] row_hit;
  logic [NUM_PC-1:0] col_hit;
  logic              covered;
  logic              latch_en;
  logic              accept;

  logic s1_valid_q, s1_cov_q, s1_last_q;

  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic [CNT_W-1:0] uncov_cnt_q, uncov_cnt_d;

  assign latch_en = (state_q == ST_IDLE) && start;
  assign accept   = (state_q == ST_CHECK) && bus.np_valid;

  // Latch the pivot configuration when an analysis starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      pr_addr_q   <= '0;
      pr_bnk_q    <= '0;
      pr_en_q     <= '0;
      pr_shared_q <= '0;
      pc_addr_q   <= '0;
      pc_bnk_q    <= '0;
      pc_en_q     <= '0;
    end else if (latch_en) begin
      pr_addr_q   <= pr_addr;
      pr_bnk_q    <= pr_bnk;
      pr_en_q     <= pr_en;
      pr_shared_q <= pr_shared;
      pc_addr_q   <= pc_addr;
      pc_bnk_q    <= pc_bnk;
      pc_en_q     <= pc_en;
    end
  end

  // Per-slot comparators: rows honour the shared flag, columns never do.
  generate
    for (genvar gi = 0; gi < NUM_PR; gi++) begin : g_row
      npc_line_match #(.ADDR_W(ADDR_W), .BNK_W(BNK_W)) u_row_match (
        .addr_i     (pr_addr_q[gi*ADDR_W +: ADDR_W]),
        .bnk_i      (pr_bnk_q[gi*BNK_W +: BNK_W]),
        .en_i       (pr_en_q[gi]),
        .shared_i   (pr_shared_q[gi]),
        .flt_addr_i (bus.np_row),
        .flt_bnk_i  (bus.np_bnk),
        .hit_o      (row_hit[gi])
      );
    end
    for (genvar gi = 0; gi < NUM_PC; gi++) begin : g_col
      npc_line_match #(.ADDR_W(ADDR_W), .BNK_W(BNK_W)) u_col_match (
        .addr_i     (pc_addr_q[gi*ADDR_W +: ADDR_W]),
        .bnk_i      (pc_bnk_q[gi*BNK_W +: BNK_W]),
        .en_i       (pc_en_q[gi]),
        .shared_i   (1'b0),
        .flt_addr_i (bus.np_col),
        .flt_bnk_i  (bus.np_bnk),
        .hit_o      (col_hit[gi])
      );
    end
  endgenerate

  assign covered = (|row_hit) || (|col_hit);

  // Stage-1: register the compare result of each accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cov_q   <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s1_cov_q   <= covered;
      s1_last_q  <= accept && bus.np_last;
    end
  end

  // Next counter values: cleared on start, saturating increments from stage-1.
  always_comb begin
    fault_cnt_d = fault_cnt_q;
    uncov_cnt_d = uncov_cnt_q;
    if (latch_en) begin
      fault_cnt_d = '0;
      uncov_cnt_d = '0;
    end else if (s1_valid_q) begin
      if (fault_cnt_q != CNT_MAX) fault_cnt_d = fault_cnt_q + CNT_ONE;
      if (!s1_cov_q && (uncov_cnt_q != CNT_MAX)) uncov_cnt_d = uncov_cnt_q + CNT_ONE;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_cnt_q <= '0;
      uncov_cnt_q <= '0;
    end else begin
      fault_cnt_q <= fault_cnt_d;
      uncov_cnt_q <= uncov_cnt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state. DRAIN waits for the last beat to leave stage-1 so the
  // counters are final by the time DONE presents them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_CHECK;
      ST_CHECK: if (accept && bus.np_last) state_d = ST_DRAIN;
      ST_DRAIN: if (s1_last_q) state_d = ST_DONE;
      ST_DONE:  if (bus.res_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.np_ready      = (state_q == ST_CHECK);
  assign busy              = (state_q == ST_CHECK) || (state_q == ST_DRAIN);
  assign bus.res_valid     = (state_q == ST_DONE);
  assign bus.res_pass      = (state_q == ST_DONE) && (uncov_cnt_q == '0);
  assign bus.res_uncov_cnt = uncov_cnt_q;
  assign bus.res_fault_cnt = fault_cnt_q;

`ifdef NPC_FAIL_LOG_EN
  logic [ADDR_W-1:0] s1_row_q, s1_col_q, fail_row_q, fail_col_q;
  logic [BNK_W-1:0]  s1_bnk_q, fail_bnk_q;
  logic              fail_seen_q;

  // Carry the fault address alongside the stage-1 compare result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_row_q <= '0;
      s1_col_q <= '0;
      s1_bnk_q <= '0;
    end else begin
      s1_row_q <= bus.np_row;
      s1_col_q <= bus.np_col;
      s1_bnk_q <= bus.np_bnk;
    end
  end

  // Keep only the first uncovered fault of the list.
  always_ff @(posedge clk) begin
    if (rst || latch_en) begin
      fail_row_q  <= '0;
      fail_col_q  <= '0;
      fail_bnk_q  <= '0;
      fail_seen_q <= 1'b0;
    end else if (s1_valid_q && !s1_cov_q && !fail_seen_q) begin
      fail_row_q  <= s1_row_q;
      fail_col_q  <= s1_col_q;
      fail_bnk_q  <= s1_bnk_q;
      fail_seen_q <= 1'b1;
    end
  end

  assign bus.res_fail_row  = fail_row_q;
  assign bus.res_fail_col  = fail_col_q;
  assign bus.res_fail_bnk  = fail_bnk_q;
  assign bus.res_fail_seen = fail_seen_q;
`endif

endmodule

// File: doc/nonpivot_cover_checker.md
# nonpivot_cover_checker

Parametrised successor of the fixed 4-row/4-column non-pivot coverage analyzer. Latches a set of NUM_PR selected pivot rows and NUM_PC selected pivot columns, then consumes a valid/ready stream of non-pivot fault addresses. For each fault it decides whether some selected spare row or column covers it, and accumulates a pass/fail verdict and an uncovered count. It sits between the pivot-selection (DSSS/RLSS) logic and the BIRA redundancy-decision controller, which reads the verdict through a result handshake.

## Interface
- NUM_PR, 4, number of pivot-row slots
- NUM_PC, 4, number of pivot-column slots
- ADDR_W, 10, row/column address width
- BNK_W, 2, bank index width
- CNT_W, 8, uncovered/fault counter width (saturating)

- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  pulse: latch pivot configuration, begin analysis (honoured in IDLE only)
- pr_addr  in  NUM_PR*ADDR_W  pivot row addresses, slot i at [i*ADDR_W +: ADDR_W]
- pr_bnk  in  NUM_PR*BNK_W  pivot row banks
- pr_en  in  NUM_PR  pivot row slot valid
- pr_shared  in  NUM_PR  row spare shared across banks (bank ignored in compare); generalises RLSS
- pc_addr  in  NUM_PC*ADDR_W  pivot column addresses
- pc_bnk  in  NUM_PC*BNK_W  pivot column banks
- pc_en  in  NUM_PC  pivot column slot valid
- np_valid  in  1  non-pivot fault beat valid
- np_ready  out  1  beat accepted when np_valid & np_ready
- np_row  in  ADDR_W  fault row address
- np_col  in  ADDR_W  fault column address
- np_bnk  in  BNK_W  fault bank
- np_last  in  1  final beat of the fault list
- busy  out  1  high in CHECK and DRAIN
- res_valid  out  1  verdict available
- res_ack  in  1  consumer accepts verdict
- res_pass  out  1  every fault covered
- res_uncov_cnt  out  CNT_W  number of uncovered faults
- res_fault_cnt  out  CNT_W  number of faults checked

## Operation
- FSM states: IDLE, CHECK, DRAIN, DONE.
- IDLE: np_ready=0. On start, latch all pr_*/pc_* inputs, clear counters, go to CHECK.
- CHECK: np_ready=1. Each accepted beat is compared against the latched pivots.
  - Row hit on slot i: pr_en[i] & pr_addr[i]==np_row & (pr_shared[i] | pr_bnk[i]==np_bnk).
  - Column hit on slot j: pc_en[j] & pc_addr[j]==np_col & pc_bnk[j]==np_bnk.
  - covered = OR of all hits.
  - The compare result is registered (stage-1: s1_valid, s1_cov, s1_last).
  - An accepted beat with np_last moves the FSM to DRAIN; np_ready drops the next cycle.
- Counters update from stage-1:
  - fault_cnt += 1 per s1_valid.
  - uncov_cnt += 1 per s1_valid & !s1_cov.
  - Both saturate at 2^CNT_W-1.
- DRAIN: one cycle while the last stage-1 entry retires, then go to DONE.
- DONE: res_valid=1, outputs held stable. res_pass = (uncov_cnt==0). On res_ack, go to IDLE.
- No pivot slots enabled: every fault is uncovered.
- Empty list is not supported: the list always has ≥1 beat.
- start outside IDLE is ignored. np_valid outside CHECK is ignored and not accepted.
- Reset mid-operation: rst in any state returns to IDLE, clears stage-1 and counters, discards the in-flight list.

## Timing
- Reset values: np_ready=0, busy=0, res_valid=0, res_pass=0, res_uncov_cnt=0, res_fault_cnt=0; FAIL_LOG outputs 0.
- Throughput: 1 beat/cycle in CHECK; np_ready does not depend on np_valid.
- Latency: last beat accepted at cycle T → DRAIN at T+1 → res_valid=1 at T+2.
- start at cycle S → CHECK (np_ready=1) at S+1.
- res_ack with res_valid → res_valid=0 and IDLE next cycle; a new start is accepted one cycle after that.

## Configuration
- NPC_FAIL_LOG_EN defined:
  - Adds outputs res_fail_row (ADDR_W), res_fail_col (ADDR_W), res_fail_bnk (BNK_W), res_fail_seen (1).
  - These capture the first uncovered fault of the list; later uncovered faults do not overwrite them.
  - Cleared on start and on rst.
- NPC_FAIL_LOG_EN undefined: these ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package bira_pkg holds:
  - the FSM state enum (IDLE/CHECK/DRAIN/DONE);
  - default ADDR_W/BNK_W localparams;
  - a pivot-entry typedef {en, shared, bnk, addr}.
- One sub-module, npc_line_match: parametrised per-slot comparator with inputs addr, bnk, en, shared-mode, fault addr/bnk, and output hit.
  - Instantiated NUM_PR times with shared enabled and NUM_PC times with shared tied to 0.
  - Replaces the separate row/column comparator blocks.

## Test plan
- Pivots PR0=(0x012,b1) and PC0=(0x3A0,b2); faults (0x012,0x001,b1), (0x055,0x3A0,b2), last → res_pass=1, fault_cnt=2, uncov=0, res_valid at T+2.
- Same pivots; fault (0x012,0x001,b3) with pr_shared[0]=0 → uncov=1, pass=0. Repeat with pr_shared[0]=1 → pass=1.
- All pr_en/pc_en=0, 3 faults → uncov=3, fault_cnt=3; with NPC_FAIL_LOG_EN, fail_* equal the first fault.
- CNT_W=4, 20 uncovered faults → uncov saturates at 15, fault_cnt saturates at 15.
- rst asserted mid-CHECK after 2 beats → next cycle IDLE, np_ready=0, counters 0; new start and a 1-beat covered list → pass=1, fault_cnt=1.
- Hold res_ack low 5 cycles in DONE → outputs stable; start ignored; np_valid beats not accepted.
